// File: rtl/conv_window_reader.sv
// conv_window_reader: requests padded rows into a 3-slot line buffer and streams 3x3 RGB windows.
module conv_window_reader #(
  parameter int WIDTH    = 418,
  parameter int PIX_W    = 8,
  parameter int OUT_ROWS = 416,
  parameter int CNT_W    = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   row_req,
  input  logic                   row_valid,
  input  logic [WIDTH*PIX_W-1:0] R_row0,
  input  logic [WIDTH*PIX_W-1:0] R_row1,
  input  logic [WIDTH*PIX_W-1:0] R_row2,
  input  logic [WIDTH*PIX_W-1:0] G_row0,
  input  logic [WIDTH*PIX_W-1:0] G_row1,
  input  logic [WIDTH*PIX_W-1:0] G_row2,
  input  logic [WIDTH*PIX_W-1:0] B_row0,
  input  logic [WIDTH*PIX_W-1:0] B_row1,
  input  logic [WIDTH*PIX_W-1:0] B_row2,
  output logic [9*PIX_W-1:0]     win_r,
  output logic [9*PIX_W-1:0]     win_g,
  output logic [9*PIX_W-1:0]     win_b,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [CNT_W-1:0]       win_col,
  output logic [CNT_W-1:0]       win_row,
  output logic                   busy,
  output logic                   frame_done
);
  typedef enum logic [2:0] {IDLE, PRIME, STREAM, WAIT_ROW, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 3);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_ROWS - 1);
  state_t state;
  logic [1:0] top, prime_cnt, ld_top;
  logic pend;
  logic [CNT_W-1:0] ld_col;
  logic [WIDTH*PIX_W-1:0] rs [3];
  logic [WIDTH*PIX_W-1:0] gs [3];
  logic [WIDTH*PIX_W-1:0] bs [3];
  logic [9*PIX_W-1:0] nr, ng, nb;
  assign rs[0] = R_row0;
  assign rs[1] = R_row1;
  assign rs[2] = R_row2;
  assign gs[0] = G_row0;
  assign gs[1] = G_row1;
  assign gs[2] = G_row2;
  assign bs[0] = B_row0;
  assign bs[1] = B_row1;
  assign bs[2] = B_row2;
  function automatic logic [1:0] slot(input logic [1:0] t, input logic [1:0] r);
    logic [2:0] s;
    s = {1'b0, t} + {1'b0, r};
    return s >= 3'd3 ? 2'(s - 3'd3) : s[1:0];
  endfunction
  function automatic logic [PIX_W-1:0] pick(input logic [WIDTH*PIX_W-1:0] row, input int p);
    return row[p*PIX_W +: PIX_W];
  endfunction
  // Next window is built from the top slot/column that will be current after this edge
  always_comb begin
    ld_top = state == WAIT_ROW ? (top == 2'd2 ? 2'd0 : top + 2'd1) : state == STREAM ? top : 2'd0;
    ld_col = (state == STREAM && win_col != LAST_COL) ? win_col + 1'b1 : '0;
    nr = '0;
    ng = '0;
    nb = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        nr[(3*r+k)*PIX_W +: PIX_W] = pick(rs[slot(ld_top, 2'(r))], int'(ld_col) + k);
        ng[(3*r+k)*PIX_W +: PIX_W] = pick(gs[slot(ld_top, 2'(r))], int'(ld_col) + k);
        nb[(3*r+k)*PIX_W +: PIX_W] = pick(bs[slot(ld_top, 2'(r))], int'(ld_col) + k);
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      top        <= '0;
      prime_cnt  <= '0;
      pend       <= 1'b0;
      row_req    <= 1'b0;
      win_r      <= '0;
      win_g      <= '0;
      win_b      <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_req    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= PRIME;
          prime_cnt <= '0;
          pend      <= 1'b0;
          top       <= '0;
          busy      <= 1'b1;
        end
        PRIME: if (!pend) begin
          row_req <= 1'b1;
          pend    <= 1'b1;
        end else if (row_valid) begin
          pend      <= 1'b0;
          prime_cnt <= prime_cnt + 2'd1;
          if (prime_cnt == 2'd2) begin
            state     <= STREAM;
            win_r     <= nr;
            win_g     <= ng;
            win_b     <= nb;
            win_valid <= 1'b1;
            win_col   <= '0;
            win_row   <= '0;
          end
        end
        STREAM: if (win_valid && win_ready) begin
          if (win_col == LAST_COL) begin
            win_valid <= 1'b0;
            if (win_row == LAST_ROW) begin
              state      <= DONE;
              frame_done <= 1'b1;
              win_row    <= '0;
              win_col    <= '0;
            end else begin
              state   <= WAIT_ROW;
              row_req <= 1'b1;
            end
          end else begin
            win_col <= ld_col;
            win_r   <= nr;
            win_g   <= ng;
            win_b   <= nb;
          end
        end
        WAIT_ROW: if (row_valid) begin
          top       <= ld_top;
          win_row   <= win_row + 1'b1;
          win_col   <= '0;
          win_r     <= nr;
          win_g     <= ng;
          win_b     <= nb;
          win_valid <= 1'b1;
          state     <= STREAM;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv_window_reader.sv
// tb_conv_window_reader: random-stimulus scoreboard bench; windows are predicted directly from the frame image.
module tb_conv_window_reader;
  localparam int WIDTH = 6, PIX_W = 8, OUT_ROWS = 3, CNT_W = 9;
  localparam int NC = WIDTH - 2, RW = WIDTH * PIX_W, WW = 9 * PIX_W;
  logic clk = 0, reset = 1, start = 0, wr_valid = 0, spur = 0, win_ready = 0;
  logic row_valid, row_req, win_valid, busy, frame_done;
  logic [RW-1:0] R_row0 = '0, R_row1 = '0, R_row2 = '0;
  logic [RW-1:0] G_row0 = '0, G_row1 = '0, G_row2 = '0;
  logic [RW-1:0] B_row0 = '0, B_row1 = '0, B_row2 = '0;
  logic [WW-1:0] win_r, win_g, win_b;
  logic [CNT_W-1:0] win_col, win_row;
  typedef struct {
    logic [WW-1:0] r, g, b;
    logic [CNT_W-1:0] col, row;
  } exp_t;
  exp_t q[$];
  logic [7:0] img [3][OUT_ROWS+2][WIDTH];
  int errors = 0, checks = 0;
  int wr_n = 0, wr_delay = 2, rr_cnt = 0, fd_cnt = 0;
  int unsigned ready_pct = 100;
  assign row_valid = wr_valid | spur;
  always #5 clk = ~clk;
  conv_window_reader #(.WIDTH(WIDTH), .PIX_W(PIX_W), .OUT_ROWS(OUT_ROWS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .row_req(row_req), .row_valid(row_valid),
    .R_row0(R_row0), .R_row1(R_row1), .R_row2(R_row2),
    .G_row0(G_row0), .G_row1(G_row1), .G_row2(G_row2),
    .B_row0(B_row0), .B_row1(B_row1), .B_row2(B_row2),
    .win_r(win_r), .win_g(win_g), .win_b(win_b), .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row), .busy(busy), .frame_done(frame_done));
  // Row writer: image row n always lands in slot n mod 3
  initial forever begin
    logic [RW-1:0] wr, wg, wb;
    @(negedge clk);
    if (row_req && !reset) begin
      repeat (wr_delay) @(negedge clk);
      for (int p = 0; p < WIDTH; p++) begin
        wr[p*PIX_W +: PIX_W] = img[0][wr_n][p];
        wg[p*PIX_W +: PIX_W] = img[1][wr_n][p];
        wb[p*PIX_W +: PIX_W] = img[2][wr_n][p];
      end
      case (wr_n % 3)
        0: begin R_row0 = wr; G_row0 = wg; B_row0 = wb; end
        1: begin R_row1 = wr; G_row1 = wg; B_row1 = wb; end
        default: begin R_row2 = wr; G_row2 = wg; B_row2 = wb; end
      endcase
      wr_n++;
      wr_valid = 1;
      @(negedge clk);
      wr_valid = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    win_ready = $urandom_range(0, 99) < ready_pct;
  end
  // Monitor: handshake scoreboard plus cycle-relative protocol checks
  initial begin
    logic pv, pstall, pacc, prv, pdone;
    logic [WW-1:0] pr, pg, pb;
    logic [CNT_W-1:0] pc, prow;
    exp_t e;
    pv = 0; pstall = 0; pacc = 0; prv = 0; pdone = 0;
    pr = '0; pg = '0; pb = '0; pc = '0; prow = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pv = 0; pstall = 0; pacc = 0; prv = 0; pdone = 0;
      end else begin
        if (pstall) begin
          checks++;
          if (!win_valid || win_r !== pr || win_g !== pg || win_b !== pb || win_col !== pc || win_row !== prow) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b col=%0d row=%0d r=%h, required valid=1 col=%0d row=%0d r=%h",
                     win_valid, win_col, win_row, win_r, pc, prow, pr);
          end
        end
        if (pacc) begin
          checks++;
          if (win_valid !== (pc != CNT_W'(NC - 1))) begin
            errors++;
            $display("FAIL valid_after_accept: col=%0d valid=%0b, required %0b", pc, win_valid, pc != CNT_W'(NC - 1));
          end
        end
        if (win_valid && !pv) begin
          checks++;
          if (!prv || rr_cnt != int'(win_row) + 3) begin
            errors++;
            $display("FAIL first_window: row=%0d prev_row_valid=%0b row_reqs=%0d, required 1 and %0d",
                     win_row, prv, rr_cnt, int'(win_row) + 3);
          end
        end
        if (pdone) begin
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle: busy=%0b, required 0", busy);
          end
        end
        if (frame_done) begin
          fd_cnt++;
          checks++;
          if (q.size() != 0 || busy !== 1'b1 || win_col !== '0 || win_row !== '0) begin
            errors++;
            $display("FAIL done_state: pending=%0d busy=%0b col=%0d row=%0d, required 0 1 0 0",
                     q.size(), busy, win_col, win_row);
          end
        end
        if (row_req) rr_cnt++;
        if (win_valid && win_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL extra_window: col=%0d row=%0d, required none", win_col, win_row);
          end else begin
            e = q.pop_front();
            if (win_r !== e.r || win_g !== e.g || win_b !== e.b || win_col !== e.col || win_row !== e.row) begin
              errors++;
              $display("FAIL window: col=%0d row=%0d r=%h g=%h b=%h, required col=%0d row=%0d r=%h g=%h b=%h",
                       win_col, win_row, win_r, win_g, win_b, e.col, e.row, e.r, e.g, e.b);
            end
          end
        end
        pstall = win_valid && !win_ready;
        pacc = win_valid && win_ready;
        pv = win_valid;
        prv = row_valid;
        pdone = frame_done;
        pr = win_r; pg = win_g; pb = win_b; pc = win_col; prow = win_row;
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic check_zero(input string name);
    checks++;
    if (row_req || win_valid || busy || frame_done || win_col != 0 || win_row != 0 ||
        win_r != 0 || win_g != 0 || win_b != 0) begin
      errors++;
      $display("FAIL %s: req=%0b valid=%0b busy=%0b done=%0b col=%0d row=%0d, required all 0",
               name, row_req, win_valid, busy, frame_done, win_col, win_row);
    end
  endtask
  // Image row y+r, pixel c+k feeds window element 3r+k of output (y,c)
  task automatic load_frame(input int f);
    exp_t e;
    for (int ch = 0; ch < 3; ch++)
      for (int n = 0; n < OUT_ROWS + 2; n++)
        for (int p = 0; p < WIDTH; p++)
          img[ch][n][p] = f == 0 ? 8'(ch * 64 + (n % 3) * 16 + p) : 8'($urandom);
    for (int y = 0; y < OUT_ROWS; y++)
      for (int c = 0; c < NC; c++) begin
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 3; k++) begin
            e.r[(3*r+k)*PIX_W +: PIX_W] = img[0][y+r][c+k];
            e.g[(3*r+k)*PIX_W +: PIX_W] = img[1][y+r][c+k];
            e.b[(3*r+k)*PIX_W +: PIX_W] = img[2][y+r][c+k];
          end
        e.col = CNT_W'(c);
        e.row = CNT_W'(y);
        q.push_back(e);
      end
    rr_cnt = 0;
    fd_cnt = 0;
    wr_n = 0;
  endtask
  task automatic wait_valid(input logic v);
    int t;
    for (t = 0; t < 300; t++) begin
      if (win_valid == v) break;
      tick();
    end
    if (t == 300) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: timeout, valid=%0b required %0b", win_valid, v);
    end
  endtask
  task automatic pulse_stream_noise();
    start = 1;
    spur = 1;
    tick();
    start = 0;
    spur = 0;
  endtask
  task automatic run_frame(input int f);
    int t;
    load_frame(f);
    wr_delay = f == 0 ? 2 : int'($urandom_range(1, 4));
    ready_pct = f == 0 ? 100 : 55;
    start = 1;
    spur = f == 1;
    tick();
    start = 0;
    spur = 0;
    if (f == 2) begin
      wait_valid(1);
      pulse_stream_noise();
      wait_valid(0);
      wait_valid(1);
      tick();
      pulse_stream_noise();
    end
    for (t = 0; t < 3000; t++) begin
      if (frame_done) break;
      tick();
    end
    checks++;
    if (t == 3000) begin
      errors++;
      $display("FAIL frame_timeout: frame %0d no frame_done, pending=%0d", f, q.size());
    end
    repeat (3) tick();
    checks++;
    if (rr_cnt != OUT_ROWS + 2 || fd_cnt != 1 || q.size() != 0 || busy) begin
      errors++;
      $display("FAIL frame_totals: frame %0d row_req=%0d done=%0d pending=%0d busy=%0b, required %0d 1 0 0",
               f, rr_cnt, fd_cnt, q.size(), busy, OUT_ROWS + 2);
    end
  endtask
  initial begin
    int t;
    repeat (3) tick();
    check_zero("reset_state");
    reset = 0;
    tick();
    for (int f = 0; f < 3; f++) run_frame(f);
    load_frame(7);
    wr_delay = 1;
    ready_pct = 50;
    start = 1;
    tick();
    start = 0;
    for (t = 0; t < 500; t++) begin
      if (win_valid && win_col == 2) break;
      tick();
    end
    if (t == 500) begin
      checks++;
      errors++;
      $display("FAIL abort_wait: col=2 never presented");
    end
    reset = 1;
    tick();
    check_zero("reset_abort");
    q.delete();
    tick();
    reset = 0;
    tick();
    check_zero("after_abort");
    run_frame(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
